// File: rtl/nand_delay_timer.sv
// Multi-channel programmable delay timer for NAND timing waits (tWB, tR, tPROG, tBERS).
// Per channel: prescaled down-counter with one-shot/auto-reload, abort, global pause, zero saturation.
module nand_delay_timer #(
    parameter int CNT_W = 16,
    parameter int N_CH  = 4,
    parameter int PRE_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*CNT_W-1:0]   count,
    input  logic [N_CH-1:0]         load,
    input  logic [N_CH-1:0]         mode,
    input  logic [N_CH-1:0]         abort,
    input  logic                    pause,
    input  logic [PRE_W-1:0]        div,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         done,
    output logic [N_CH-1:0]         expired
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_counter;
        logic [CNT_W-1:0] r_reload;
        logic [PRE_W-1:0] r_pre;
        logic             r_mode;
        logic             r_busy;
        logic             r_done;
        logic             r_expired;
        logic [CNT_W-1:0] w_load_val;
        logic             w_tick;

        assign w_load_val = count[g*CNT_W +: CNT_W];
        // >= rather than == so lowering div mid-count fires on the next edge instead of stalling
        assign w_tick     = (r_pre >= div);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_counter <= '0;
                r_reload  <= '0;
                r_pre     <= '0;
                r_mode    <= 1'b0;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
                r_expired <= 1'b0;
            end else if (load[g]) begin
                r_pre <= '0;
                if (w_load_val != '0) begin
                    r_counter <= w_load_val;
                    r_reload  <= w_load_val;
                    r_mode    <= mode[g];
                    r_busy    <= 1'b1;
                    r_done    <= 1'b0;
                    r_expired <= 1'b0;
                end else begin
                    r_counter <= '0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_expired <= 1'b1;
                end
            end else if (abort[g]) begin
                r_counter <= '0;
                r_pre     <= '0;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
                r_expired <= 1'b0;
            end else begin
                r_done <= 1'b0;
                if (r_busy && !pause) begin
                    if (w_tick) begin
                        r_pre <= '0;
                        if (r_counter == CNT_W'(1)) begin
                            r_done    <= 1'b1;
                            r_expired <= 1'b1;
                            if (r_mode) begin
                                r_counter <= r_reload;
                            end else begin
                                r_counter <= '0;
                                r_busy    <= 1'b0;
                            end
                        end else begin
                            r_counter <= r_counter - CNT_W'(1);
                        end
                    end else begin
                        r_pre <= r_pre + PRE_W'(1);
                    end
                end
            end
        end

        assign busy[g]    = r_busy;
        assign done[g]    = r_done;
        assign expired[g] = r_expired;
    end

endmodule

// File: doc/nand_delay_timer.md
# nand_delay_timer

Multi-channel, parametrised programmable delay timer for the NAND flash controller timing path. It generates tWB, tR, tPROG, tBERS and similar waits for the command sequencer. Each channel is loaded with a tick count and asserts a one-cycle done strobe plus a sticky expired flag after exactly count × (div+1) clocks. Additions over the single-channel down-counter it replaces: per-channel one-shot/auto-reload mode, a per-channel clock prescaler, abort, global pause, and saturation at zero instead of wrap-around.

## Interface
- CNT_W, 16, counter width per channel (ticks)
- N_CH, 4, number of independent channels
- PRE_W, 8, prescaler divide-value width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- count  in  N_CH*CNT_W  load values; channel i uses bits [i*CNT_W +: CNT_W]
- load  in  N_CH  per-channel load/restart strobe
- mode  in  N_CH  sampled on load: 0 = one-shot, 1 = auto-reload
- abort  in  N_CH  per-channel cancel
- pause  in  1  freezes all prescalers and counters while high
- div  in  PRE_W  shared prescale value; tick period = div+1 clocks
- busy  out  N_CH  channel is counting
- done  out  N_CH  one-cycle expiry strobe, registered
- expired  out  N_CH  sticky expiry flag

## Operation
- Per-channel registers: counter[CNT_W], reload[CNT_W], pre[PRE_W], mode_r, busy, done, expired. All reset to 0 asynchronously. Every output is 0 during and after reset.
- Priority per channel, per edge: load > abort > count. Pause never blocks load or abort.
- On load with count=N≠0:
  - counter←N, reload←N, mode_r←mode, pre←0, busy←1, expired←0.
  - done←0. Any pending strobe is discarded.
- On load with N=0:
  - busy←0, counter←0, done←1 on this edge, expired←1.
  - The mode is ignored.
- On abort with no load: busy←0, counter←0, pre←0, expired←0, done←0. No strobe is produced.
- Counting, when busy, pause=0, and no load or abort:
  - If pre ≥ div, a tick occurs: pre←0 and counter decrements. Otherwise pre←pre+1.
  - The ≥ comparison prevents a stall when div is lowered mid-count.
  - A change to div takes effect from the next tick.
- Expiry (tick with counter=1):
  - done←1 for exactly one cycle; expired←1.
  - One-shot: counter←0, busy←0.
  - Auto-reload: counter←reload, busy stays 1, and pre restarts from 0. Strobes repeat every reload×(div+1) clocks until load or abort.
- When not busy, counter holds at 0 and never wraps. Ticks are ignored.
- Pause=1: pre and counter hold. Already-asserted done still falls after one cycle.
- Channels are fully independent; simultaneous loads or expiries on several channels are legal.

## Timing
- Load sampled high at edge k with N≥1: done is high for the cycle after edge k + N×(div+1), and low on the following edge.
- busy rises after edge k and falls on the same edge that raises done (one-shot).
- Load of 0 at edge k: done is high for the cycle after edge k.
- Load arriving on the expiry edge: the load wins and there is no done strobe.
- Each cycle of pause extends the expiry by one clock.
- rst asserted mid-count: all state clears immediately, regardless of clk. After deassertion, the block is idle until the next load.
- No combinational paths from inputs to outputs.

## Test plan
- Reset: hold rst with load/count toggling → busy, done and expired stay 0. Release, load ch0 N=5, div=0 → done high exactly 5 cycles after the load cycle, for one cycle; expired stays 1.
- Prescale: ch1 N=3, div=3 → done 12 cycles after load. Change div from 7 to 1 mid-count (pre=5) → next tick on the following edge, with no stall.
- Auto-reload: ch2 N=4, mode=1, div=0 → done every 4 cycles and busy constantly 1. Abort → strobes stop, expired=0, busy=0.
- Boundaries: load N=0 → done 1 cycle after load, busy never rises. Load N=2^CNT_W−1, div=0 → single strobe at the expected cycle, with no wrap afterwards.
- Collisions: reload ch3 on its expiry edge → no strobe, and the count restarts. Assert load and abort together → load wins. Expire all 4 channels on the same edge → all done strobes coincide.
- Pause: ch0 N=6, div=0, pause high for 3 cycles mid-count → done at 9 cycles. Assert rst mid-count → outputs clear immediately and no strobe follows.
